axi_lite_regfile: RTL and testbench
===================================

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers (2..256).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port AWADDR  input  ADDR_WIDTH  write address.
REQ-007 SHALL have port AWVALID / AWREADY  input / output  1 / 1  write-address handshake.
REQ-008 SHALL have port WDATA  input  DATA_WIDTH  write data.
REQ-009 SHALL have port WSTRB  input  DATA_WIDTH/8  byte enables.
REQ-010 SHALL have port WVALID / WREADY  input / output  1 / 1  write-data handshake.
REQ-011 SHALL have port BRESP  output  2  write response (00 OKAY, 10 SLVERR).
REQ-012 SHALL have port BVALID / BREADY  output / input  1 / 1  response handshake.
REQ-013 SHALL have port ARADDR  input  ADDR_WIDTH  read address.
REQ-014 SHALL have port ARVALID / ARREADY  input / output  1 / 1  read-address handshake.
REQ-015 SHALL have port RDATA  output  DATA_WIDTH  read data.
REQ-016 SHALL have port RRESP  output  2  read response.
REQ-017 SHALL have port RVALID / RREADY  output / input  1 / 1  read-data handshake.
REQ-018 SHALL have port regs_o  output  NUM_REGS*DATA_WIDTH  flat register contents; reg i at bits [32i+31:32i].

Function
REQ-019 Register index SHALL be addr[ADDR_WIDTH-1:2]; addr[1:0] are ignored; index >= NUM_REGS is out of range.
REQ-020 Write FSM states SHALL be WR_IDLE and WR_RESP; AW and W are captured independently into holding registers with aw_held/w_held flags.
REQ-021 In WR_IDLE: AWREADY = !aw_held and WREADY = !w_held; in WR_RESP both SHALL be 0.
REQ-022 When aw_held and w_held are both set, or become set at edge N, the write SHALL commit at edge N+1: only bytes with WSTRB=1 updated; FSM to WR_RESP; BVALID=1; flags cleared.
REQ-023 Out-of-range write SHALL change no register and return BRESP=SLVERR; in-range SHALL return OKAY.
REQ-024 In WR_RESP, BVALID and BRESP SHALL hold stable until BVALID&&BREADY, then return to WR_IDLE the next cycle.
REQ-025 Read FSM states SHALL be RD_IDLE (ARREADY=1) and RD_DATA (ARREADY=0, RVALID=1).
REQ-026 On ARVALID&&ARREADY at edge N, RDATA SHALL show the register value before edge N (or 0 if out of range, with RRESP=SLVERR); RVALID=1 from N.
REQ-027 RDATA, RRESP and RVALID SHALL hold until RVALID&&RREADY; the next ARREADY is 1 in the following cycle.
REQ-028 Read and write channels SHALL operate concurrently; a read sampled on the same edge a write commits to the same register returns the old value.
REQ-029 VALID SHALL never depend combinationally on READY; no output is combinational from any input.
REQ-030 regs_o SHALL reflect a write in the cycle after commit.

Reset
REQ-031 On rst_n=0 at a rising edge: all registers, holding registers and flags SHALL be 0; FSMs go to WR_IDLE and RD_IDLE; BVALID=RVALID=0; BRESP=RRESP=00; RDATA=0.
REQ-032 Reset asserted mid-transaction SHALL discard pending AW/W/B/R state without a commit; AWREADY=WREADY=ARREADY=1 in the first cycle after reset.

Structure
REQ-033 The package axi_lite_pkg SHALL hold the resp_t enum (OKAY=2'b00, SLVERR=2'b10) and the wr_state_t and rd_state_t enums.
REQ-034 A single sub-module, axi_lite_regfile_core (byte-strobed register array with a synchronous write port and an asynchronous read port), SHALL be instantiated once.

Verification
REQ-035 AW and W in the same cycle, addr 0x08, data 0xDEADBEEF, WSTRB 0xF -> BVALID the next cycle with OKAY; reg2=0xDEADBEEF.
REQ-036 W 3 cycles before AW, addr 0x04, data 0x12345678, WSTRB 0x3 over 0xFFFFFFFF -> reg1=0xFFFF5678; WREADY=0 while held.
REQ-037 Write to 0x40 with NUM_REGS=16 -> SLVERR, no register changed; read of 0x40 -> RDATA=0, RRESP=SLVERR.
REQ-038 BREADY held 0 for 5 cycles -> BVALID/BRESP stable; AWREADY=WREADY=0; a new AW is not accepted until after the B handshake.
REQ-039 Read of reg3 on the same edge a write of 0xA5A5A5A5 commits to reg3 (old 0x0) -> RDATA=0x0; the next read returns 0xA5A5A5A5.
REQ-040 rst_n=0 while BVALID=1 -> next cycle BVALID=0, all regs_o=0, all READY=1.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register file.
//   resp_t     : AXI response codes used on BRESP / RRESP
//   wr_state_t : write-channel FSM states
//   rd_state_t : read-channel FSM states
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [0:0] {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic [0:0] {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  localparam int unsigned BYTE_W = 8;

  function automatic resp_t range_resp(input logic in_range);
    return in_range ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite_regfile_core.sv
// Byte-strobed register array: one synchronous write port, one asynchronous read port,
// plus a flat view of every register.
//   clk, rst_n : clock, synchronous active-low reset (clears all registers)
//   wr_en      : commit wr_data into register wr_idx, bytes selected by wr_strb
//   rd_idx     : combinational read select -> rd_data
//   regs       : register r at bits [r*DATA_WIDTH +: DATA_WIDTH]
module axi_lite_regfile_core
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (wr_idx == IDX_W'(r) && wr_strb[b]) begin
            mem_q[r][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  // Compare-based mux so a non-power-of-two NUM_REGS never indexes past the array.
  always_comb begin
    rd_data = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (rd_idx == IDX_W'(r)) begin
        rd_data = mem_q[r];
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      regs[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[r];
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers.
//   clk, rst_n          : clock, synchronous active-low reset
//   AW*/W*/B*           : write address, write data and write response channels
//   AR*/R*              : read address and read data channels
//   regs_o              : flat register contents, reg i at [32i+31:32i]
// Register index is addr[ADDR_WIDTH-1:2]; indices >= NUM_REGS answer SLVERR.
// All outputs come straight from flops; the two channels run independently.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned STRB_W     = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = ADDR_WIDTH - 2;
  localparam int unsigned IDX_W1     = IDX_W + 1;
  localparam int unsigned CORE_IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W:0] NUM_REGS_EXT = IDX_W1'(NUM_REGS);

  // Write channel state
  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;

  // Read channel state
  rd_state_t             rd_state_q, rd_state_d;
  logic                  rvalid_q, rvalid_d;
  resp_t                 rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  core_wr_en;
  logic [DATA_WIDTH-1:0] core_rd_data;
  logic [IDX_W-1:0]      ar_idx;
  logic                  aw_in_range;
  logic                  ar_in_range;

  // Byte-offset address bits carry no information for word registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  assign ar_idx      = ARADDR[ADDR_WIDTH-1:2];
  assign aw_in_range = ({1'b0, aw_idx_q} < NUM_REGS_EXT);
  assign ar_in_range = ({1'b0, ar_idx} < NUM_REGS_EXT);

  axi_lite_regfile_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (CORE_IDX_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (core_wr_en),
    .wr_idx  (aw_idx_q[CORE_IDX_W-1:0]),
    .wr_data (wdata_q),
    .wr_strb (wstrb_q),
    .rd_idx  (ar_idx[CORE_IDX_W-1:0]),
    .rd_data (core_rd_data),
    .regs    (regs_o)
  );

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    core_wr_en = 1'b0;

    unique case (wr_state_q)
      WR_IDLE: begin
        if (aw_held_q && w_held_q) begin
          // Both halves captured: commit this edge. Out-of-range is answered, not stored.
          core_wr_en = aw_in_range;
          bresp_d    = range_resp(aw_in_range);
          bvalid_d   = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WR_RESP;
        end else begin
          if (AWVALID && !aw_held_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = AWADDR[ADDR_WIDTH-1:2];
          end
          if (WVALID && !w_held_q) begin
            w_held_d = 1'b1;
            wdata_d  = WDATA;
            wstrb_d  = WSTRB;
          end
        end
      end
      WR_RESP: begin
        if (BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;

    unique case (rd_state_q)
      RD_IDLE: begin
        if (ARVALID) begin
          // Array is read before this edge's write lands, so a same-edge write is not seen.
          rdata_d    = ar_in_range ? core_rd_data : '0;
          rresp_d    = range_resp(ar_in_range);
          rvalid_d   = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign AWREADY = (wr_state_q == WR_IDLE) && !aw_held_q;
  assign WREADY  = (wr_state_q == WR_IDLE) && !w_held_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = (rd_state_q == RD_IDLE);
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboard bench for axi_lite_regfile: expected B/R responses are queued when a
// transaction is driven and popped when the DUT presents them.
module tb_axi_lite_regfile;
  import axi_lite_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DW-1:0]     WDATA;
  logic [DW/8-1:0]   WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [AW-1:0]     ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DW-1:0]     RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  logic [NR*DW-1:0]  regs;

  axi_lite_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .regs_o  (regs)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] mdl [NR];
  logic [1:0]  b_q [$];
  logic [33:0] r_q [$];  // {resp, data}

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input int unsigned i);
    return regs[32*i +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    logic [29:0] idx;
    idx = addr[31:2];
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
      end
      b_q.push_back(OKAY);
    end else begin
      b_q.push_back(SLVERR);
    end
  endtask

  task automatic push_read(input logic [31:0] addr);
    logic [29:0] idx;
    idx = addr[31:2];
    if (idx < NR) r_q.push_back({OKAY, mdl[idx]});
    else          r_q.push_back({SLVERR, 32'h0});
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) check_eq($sformatf("%s_reg%0d", tag, i), reg_of(i), mdl[i]);
  endtask

  task automatic send_aw(input logic [31:0] addr);
    int n = 0;
    AWADDR  = addr;
    AWVALID = 1'b1;
    while (!AWREADY && n < 40) begin tick(); n++; end
    check_eq("aw_accept", AWREADY, 1'b1);
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    WDATA  = data;
    WSTRB  = strb;
    WVALID = 1'b1;
    while (!WREADY && n < 40) begin tick(); n++; end
    check_eq("w_accept", WREADY, 1'b1);
    tick();
    WVALID = 1'b0;
  endtask

  // AW and W presented together.
  task automatic send_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    model_write(addr, data, strb);
    AWADDR = addr; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    while (!(AWREADY && WREADY) && n < 40) begin tick(); n++; end
    check_eq("wr_accept", AWREADY && WREADY, 1'b1);
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
  endtask

  task automatic collect_b(input string tag);
    int n = 0;
    logic [1:0] exp;
    BREADY = 1'b1;
    while (!BVALID && n < 40) begin tick(); n++; end
    check_eq({tag, "_bvalid"}, BVALID, 1'b1);
    exp = b_q.pop_front();
    check_eq({tag, "_bresp"}, BRESP, exp);
    tick();
    BREADY = 1'b0;
    check_eq({tag, "_bvalid_drop"}, BVALID, 1'b0);
  endtask

  task automatic collect_r(input string tag);
    int n = 0;
    logic [33:0] exp;
    RREADY = 1'b1;
    while (!RVALID && n < 40) begin tick(); n++; end
    check_eq({tag, "_rvalid"}, RVALID, 1'b1);
    exp = r_q.pop_front();
    check_eq({tag, "_rdata"}, RDATA, exp[31:0]);
    check_eq({tag, "_rresp"}, RRESP, exp[33:32]);
    tick();
    RREADY = 1'b0;
    check_eq({tag, "_rvalid_drop"}, RVALID, 1'b0);
    check_eq({tag, "_arready_back"}, ARREADY, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr, input string tag);
    int n = 0;
    push_read(addr);
    ARADDR  = addr;
    ARVALID = 1'b1;
    while (!ARREADY && n < 40) begin tick(); n++; end
    check_eq({tag, "_ar_accept"}, ARREADY, 1'b1);
    tick();
    ARVALID = 1'b0;
    collect_r(tag);
  endtask

  task automatic wait_bvalid();
    int n = 0;
    while (!BVALID && n < 40) begin tick(); n++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_n = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_awready", AWREADY, 1'b1);
    check_eq("rst_wready", WREADY, 1'b1);
    check_eq("rst_arready", ARREADY, 1'b1);
    check_eq("rst_bvalid", BVALID, 1'b0);
    check_eq("rst_rvalid", RVALID, 1'b0);
    check_eq("rst_rdata", RDATA, 32'h0);
    check_eq("rst_bresp", BRESP, 2'b00);
    check_eq("rst_rresp", RRESP, 2'b00);
    check_regs("rst");

    // AW and W in the same cycle: capture at N, commit at N+1
    model_write(32'h08, 32'hDEADBEEF, 4'hF);
    AWADDR = 32'h08; AWVALID = 1'b1;
    WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
    check_eq("same_awready", AWREADY, 1'b1);
    check_eq("same_wready", WREADY, 1'b1);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check_eq("same_bvalid_early", BVALID, 1'b0);
    tick();
    check_eq("same_bvalid", BVALID, 1'b1);
    check_eq("same_reg2", reg_of(2), 32'hDEADBEEF);
    collect_b("same");
    check_eq("same_awready_after", AWREADY, 1'b1);

    // W three cycles ahead of AW, partial strobe over all-ones
    send_wr(32'h04, 32'hFFFFFFFF, 4'hF);
    collect_b("fill1");
    model_write(32'h04, 32'h12345678, 4'h3);
    send_w(32'h12345678, 4'h3);
    for (int i = 0; i < 3; i++) begin
      check_eq("wheld_wready", WREADY, 1'b0);
      check_eq("wheld_bvalid", BVALID, 1'b0);
      tick();
    end
    send_aw(32'h04);
    collect_b("wfirst");
    check_eq("wfirst_reg1", reg_of(1), 32'hFFFF5678);
    check_regs("wfirst");

    // Out-of-range write and read
    send_wr(32'h40, 32'h0BADF00D, 4'hF);
    collect_b("oor_wr");
    check_regs("oor");
    do_read(32'h40, "oor_rd");
    do_read(32'h08, "rd2");
    do_read(32'h0B, "rd2_lsb");

    // B back-pressure: response stable, no new AW accepted
    send_wr(32'h14, 32'h11223344, 4'hF);
    wait_bvalid();
    AWADDR = 32'h18; AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_bvalid", BVALID, 1'b1);
      check_eq("bp_bresp", BRESP, OKAY);
      check_eq("bp_awready", AWREADY, 1'b0);
      check_eq("bp_wready", WREADY, 1'b0);
      tick();
    end
    collect_b("bp");
    check_eq("bp_awready_after", AWREADY, 1'b1);
    tick();
    AWVALID = 1'b0;
    check_eq("bp_aw_taken", AWREADY, 1'b0);
    model_write(32'h18, 32'h55667788, 4'hF);
    send_w(32'h55667788, 4'hF);
    collect_b("bp2");
    check_eq("bp_reg6", reg_of(6), 32'h55667788);

    // Read sampled on the commit edge of a write to the same register sees the old value
    push_read(32'h0C);
    model_write(32'h0C, 32'hA5A5A5A5, 4'hF);
    AWADDR = 32'h0C; AWVALID = 1'b1;
    WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h0C; ARVALID = 1'b1;
    check_eq("coll_arready", ARREADY, 1'b1);
    tick();
    ARVALID = 1'b0;
    collect_b("coll_b");
    collect_r("coll_r");
    do_read(32'h0C, "coll_again");

    // Random mix of writes and reads, including out-of-range indices
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 4) == 0) a = a + 32'h40;
      if ($urandom_range(0, 1) == 0) begin
        send_wr(a, $urandom, 4'($urandom_range(0, 15)));
        collect_b("rnd_wr");
      end else begin
        do_read(a, "rnd_rd");
      end
    end
    check_regs("rnd");

    // Reset while BVALID is high
    send_wr(32'h1C, 32'hCAFEF00D, 4'hF);
    wait_bvalid();
    check_eq("rstb_bvalid_pre", BVALID, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    b_q.delete();
    model_clear();
    check_eq("rstb_bvalid", BVALID, 1'b0);
    check_eq("rstb_awready", AWREADY, 1'b1);
    check_eq("rstb_wready", WREADY, 1'b1);
    check_eq("rstb_arready", ARREADY, 1'b1);
    check_regs("rstb");

    // Held AW is discarded by reset; a later lone W must not commit
    AWADDR = 32'h20; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rsta_awready", AWREADY, 1'b1);
    send_w(32'h77777777, 4'hF);
    for (int i = 0; i < 3; i++) begin
      check_eq("rsta_no_b", BVALID, 1'b0);
      tick();
    end
    check_eq("rsta_reg8", reg_of(8), 32'h0);
    model_write(32'h24, 32'h77777777, 4'hF);
    send_aw(32'h24);
    collect_b("rsta");
    check_regs("rsta");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
